vga_timing_gen: RTL and testbench

//  Free-running XGA (1024x768 @ 60 Hz, 65 MHz pixel clock) raster timing generator.

---
 rtl/vga_timing_gen.sv | 97 +++++++++
 tb/tb_vga_timing_gen.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   Free-running raster timing generator, XGA 1024x768 @ 60 Hz by default
//   (65 MHz pixel clock, 1344 x 806 total raster). It produces a pixel-aligned
//   bundle: counts, syncs, blanks and a frame-origin pulse. Every output is a
//   flop, and all of them describe the same pixel in the same cycle.
//
// Ports
//   clk_in       in   1   pixel clock, all logic on the rising edge
//   rst          in   1   asynchronous, active-high reset
//   hcount_out   out  12  horizontal pixel index, 0..H_TOTAL-1
//   hsync_out    out  1   horizontal sync, active-high
//   hblnk_out    out  1   horizontal blanking, active-high
//   vcount_out   out  12  vertical line index, 0..V_TOTAL-1
//   vsync_out    out  1   vertical sync, active-high
//   vblnk_out    out  1   vertical blanking, active-high
//   frame_start  out  1   one-cycle pulse while hcount_out==0 && vcount_out==0
//
// The flag flops decode the next-count values. Each flag therefore lands in
// the same cycle as the count it describes, with no one-pixel skew.
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 1024,
  parameter int unsigned H_FP     = 24,
  parameter int unsigned H_SYNC   = 136,
  parameter int unsigned H_BP     = 160,
  parameter int unsigned V_ACTIVE = 768,
  parameter int unsigned V_FP     = 3,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_BP     = 29
) (
  input  logic        clk_in,
  input  logic        rst,
  output logic [11:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [11:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic        frame_start
);

  // Decode thresholds. They are 12 bits wide so that every compare is done
  // on full 12-bit count values.
  localparam logic [11:0] H_LAST       = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] H_BLNK_START = 12'(H_ACTIVE);
  localparam logic [11:0] H_SYNC_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SYNC_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_LAST       = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [11:0] V_BLNK_START = 12'(V_ACTIVE);
  localparam logic [11:0] V_SYNC_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SYNC_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

  logic        h_wrap;
  logic [11:0] h_next;
  logic [11:0] v_next;

  // The wraps are explicit compares against the last index. They never rely
  // on the counters overflowing at 4096.
  always_comb begin
    // NOTE: every signal gets a default before any branch so that no path
    // leaves it unassigned; otherwise a latch would be inferred.
    h_wrap = (hcount_out == H_LAST);
    h_next = h_wrap ? 12'd0 : hcount_out + 12'd1;
    v_next = vcount_out;
    if (h_wrap) begin
      v_next = (vcount_out == V_LAST) ? 12'd0 : vcount_out + 12'd1;
    end
  end

  // NOTE: the reset is asynchronous, so it appears in the sensitivity list
  // and clears every flop at once, mid-cycle if necessary. frame_start is
  // cleared as well, so it stays low during reset even though the counts
  // read as the origin.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      hcount_out  <= '0;
      vcount_out  <= '0;
      hsync_out   <= 1'b0;
      hblnk_out   <= 1'b0;
      vsync_out   <= 1'b0;
      vblnk_out   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments. Every flop samples the pre-edge
      // values, so the order of these statements does not matter.
      hcount_out  <= h_next;
      vcount_out  <= v_next;
      hblnk_out   <= (h_next >= H_BLNK_START);
      hsync_out   <= (h_next >= H_SYNC_START) && (h_next < H_SYNC_END);
      vblnk_out   <= (v_next >= V_BLNK_START);
      vsync_out   <= (v_next >= V_SYNC_START) && (v_next < V_SYNC_END);
      frame_start <= (h_next == 12'd0) && (v_next == 12'd0);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//   Bench for vga_timing_gen. It uses two instances on a shared clock and
//   reset:
//     dut_b : default XGA timing. Covers reset, the first lines and the
//             full horizontal decode.
//     dut_s : a reduced raster, 25 x 13 (325 cycles per frame). A full XGA
//             frame is over a million cycles, so this instance covers the
//             vertical decode, the frame wrap and the frame period.
//   Model processes push the expected bundle for each edge into a queue. The
//   expected bundle is computed from the number of edges since reset
//   release. Monitor processes pop one entry per cycle on the falling edge
//   and compare it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

  typedef struct packed {
    logic [11:0] h;
    logic [11:0] v;
    logic        hs;
    logic        hb;
    logic        vs;
    logic        vb;
    logic        fs;
  } bundle_t;

  // Reduced raster for the small instance.
  localparam int S_HA = 16, S_HF = 2, S_HS = 4, S_HB = 3;   // 25 per line
  localparam int S_VA = 8,  S_VF = 1, S_VS = 2, S_VB = 2;   // 13 lines
  localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VA + S_VF + S_VS + S_VB;
  localparam int S_FRAME = S_HT * S_VT;                     // 325

  logic clk_in = 1'b0;
  logic rst    = 1'b1;

  logic [11:0] hcount_b, vcount_b, hcount_s, vcount_s;
  logic hsync_b, hblnk_b, vsync_b, vblnk_b, fs_b;
  logic hsync_s, hblnk_s, vsync_s, vblnk_s, fs_s;

  always #5 clk_in = ~clk_in;

  vga_timing_gen dut_b (
    .clk_in(clk_in), .rst(rst),
    .hcount_out(hcount_b), .hsync_out(hsync_b), .hblnk_out(hblnk_b),
    .vcount_out(vcount_b), .vsync_out(vsync_b), .vblnk_out(vblnk_b),
    .frame_start(fs_b)
  );

  vga_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
  ) dut_s (
    .clk_in(clk_in), .rst(rst),
    .hcount_out(hcount_s), .hsync_out(hsync_s), .hblnk_out(hblnk_s),
    .vcount_out(vcount_s), .vsync_out(vsync_s), .vblnk_out(vblnk_s),
    .frame_start(fs_s)
  );

  bundle_t act_b, act_s;
  assign act_b = {hcount_b, vcount_b, hsync_b, hblnk_b, vsync_b, vblnk_b, fs_b};
  assign act_s = {hcount_s, vcount_s, hsync_s, hblnk_s, vsync_s, vblnk_s, fs_s};

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected bundle after n edges since reset release (n >= 1).
  function automatic bundle_t model(input int n,
                                    input int hact, input int hfp, input int hsw, input int hbp,
                                    input int vact, input int vfp, input int vsw, input int vbp);
    bundle_t r;
    int ht, vt, k, h, v;
    ht   = hact + hfp + hsw + hbp;
    vt   = vact + vfp + vsw + vbp;
    k    = n % (ht * vt);
    h    = k % ht;
    v    = k / ht;
    r.h  = 12'(h);
    r.v  = 12'(v);
    r.hb = (h >= hact);
    r.hs = (h >= hact + hfp) && (h < hact + hfp + hsw);
    r.vb = (v >= vact);
    r.vs = (v >= vact + vfp) && (v < vact + vfp + vsw);
    r.fs = (h == 0) && (v == 0);
    return r;
  endfunction

  // ---------------- expected-value producers (scoreboard push) -------------
  bundle_t q_b[$];
  bundle_t q_s[$];
  int n_b = 0;
  int n_s = 0;

  always @(posedge clk_in or posedge rst) begin
    if (rst) begin
      n_b = 0;
      n_s = 0;
      q_b.delete();
      q_s.delete();
    end else begin
      n_b++;
      n_s++;
      q_b.push_back(model(n_b, 1024, 24, 136, 160, 768, 3, 6, 29));
      q_s.push_back(model(n_s, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB));
    end
  end

  // ---------------- monitors (scoreboard pop/compare) ----------------------
  int popped_b = 0;
  int s_cyc = 0;
  int s_last_fs = -1;
  int s_vs_cnt = 0;
  int s_vb_cnt = 0;
  int s_frames = 0;

  always @(negedge clk_in) begin
    if (rst) begin
      popped_b = 0;
    end else if (q_b.size() > 0) begin
      check("bundle_xga", act_b, q_b.pop_front());
      popped_b++;
    end
  end

  always @(negedge clk_in) begin
    if (rst) begin
      s_cyc     = 0;
      s_last_fs = -1;
      s_vs_cnt  = 0;
      s_vb_cnt  = 0;
      s_frames  = 0;
    end else if (q_s.size() > 0) begin
      s_cyc++;
      check("bundle_small", act_s, q_s.pop_front());
      check("small_hrange", 64'(hcount_s <= 12'(S_HT - 1)), 64'd1);
      check("small_vrange", 64'(vcount_s <= 12'(S_VT - 1)), 64'd1);
      if (fs_s) begin
        // The first pulse comes one whole frame after release; after that,
        // pulses are exactly one frame period apart.
        if (s_last_fs < 0) check("first_frame_start", 64'(s_cyc), 64'(S_FRAME));
        else               check("frame_period", 64'(s_cyc - s_last_fs), 64'(S_FRAME));
        check("vsync_cycles_per_frame", 64'(s_vs_cnt), 64'(S_VS * S_HT));
        check("vblnk_cycles_per_frame", 64'(s_vb_cnt), 64'((S_VT - S_VA) * S_HT));
        s_last_fs = s_cyc;
        s_vs_cnt  = 0;
        s_vb_cnt  = 0;
        s_frames++;
      end else begin
        if (vsync_s) s_vs_cnt++;
        if (vblnk_s) s_vb_cnt++;
      end
    end
  end

  // ---------------- directed stimulus --------------------------------------
  initial begin
    int hs_cnt, hs_first, hs_last, hb_cnt, hb_first;

    // Power-up reset: every output is 0, frame_start included.
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check("reset_xga", act_b, '0);
    check("reset_small", act_s, '0);
    #2 rst = 1'b0;

    // Run to hcount=500, then assert reset mid-cycle, away from any edge.
    repeat (500) @(posedge clk_in);
    #1 check("pre_reset_hcount", 64'(hcount_b), 64'd500);
    #2 rst = 1'b1;
    #1 check("async_reset_xga", act_b, '0);
    check("async_reset_small", act_s, '0);

    // Release: one edge gives hcount=1; after 1343 more edges, (0,1).
    @(negedge clk_in);
    #2 rst = 1'b0;
    @(posedge clk_in);
    #1 check("first_edge", act_b, {12'd1, 12'd0, 5'b00000});
    repeat (1343) @(posedge clk_in);
    #1 check("line_wrap", act_b, {12'd0, 12'd1, 5'b00000});

    // Scan line 1 from hcount=0 to 1343 and record where the flags sit.
    hs_cnt = 0; hs_first = -1; hs_last = -1; hb_cnt = 0; hb_first = -1;
    for (int i = 0; i < 1344; i++) begin
      if (i > 0) begin
        @(posedge clk_in);
        #1;
      end
      if (hsync_b) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(hcount_b);
        hs_last = int'(hcount_b);
      end
      if (hblnk_b) begin
        hb_cnt++;
        if (hb_first < 0) hb_first = int'(hcount_b);
      end
    end
    check("hsync_width", 64'(hs_cnt), 64'd136);
    check("hsync_first", 64'(hs_first), 64'd1048);
    check("hsync_last", 64'(hs_last), 64'd1183);
    check("hblnk_rise", 64'(hb_first), 64'd1024);
    check("hblnk_width", 64'(hb_cnt), 64'd320);
    @(posedge clk_in);
    #1 check("hblnk_fall", {hcount_b, vcount_b, hblnk_b}, {12'd0, 12'd2, 1'b0});

    // Let the small raster complete several frames (wraps and pulse spacing
    // are checked by its monitor).
    repeat (4 * S_FRAME) @(posedge clk_in);
    @(negedge clk_in);
    #1;
    check("small_frames_seen", 64'(s_frames >= 3), 64'd1);
    check("xga_scoreboard_drained", 64'(popped_b), 64'(n_b));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net in case stimulus stalls.
  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
